// File: rtl/win_pkg.sv
// Shared types and width helpers for the window mean normaliser family.
package win_pkg;

  typedef enum logic [1:0] {FILL, CALC, DRAIN} win_state_t;

  function automatic int unsigned sum_width(int unsigned pix_w, int unsigned win_dim);
    return pix_w + 2 * $clog2(win_dim);
  endfunction

  function automatic int unsigned cnt_width(int unsigned win_dim);
    return 2 * $clog2(win_dim) + 1;
  endfunction

  // Round half up adds half an LSB of the result before the shift.
  function automatic logic [63:0] mean_of(logic [63:0] sum, int unsigned shift, logic round);
    logic [63:0] s;
    s = sum;
    if (round) s = s + ((64'd1 << shift) >> 1);
    return s >> shift;
  endfunction

endpackage

// File: rtl/win_buf.sv
// Simple dual-port pixel buffer with a registered read port.
module win_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/window_mean_stream.sv
// Buffers one square window, computes its mean and replays each pixel minus the mean.
module window_mean_stream
  import win_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned WIN_DIM    = 16,
  parameter int unsigned ROUND_MEAN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W:0]   out_data,
  output logic             out_last,
  output logic [PIX_W-1:0] out_mean
);

  localparam int unsigned N     = WIN_DIM * WIN_DIM;
  localparam int unsigned LOG_N = 2 * $clog2(WIN_DIM);
  localparam int unsigned AW    = LOG_N;
  localparam int unsigned SUM_W = sum_width(PIX_W, WIN_DIM);
  localparam int unsigned CNT_W = cnt_width(WIN_DIM);

  win_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] sum_q;
  logic [PIX_W-1:0] mean_q;

  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] rd_data;
  logic             cnt_at_end;
  logic [PIX_W:0]   diff;

  assign cnt_at_end = (cnt_q == CNT_W'(N - 1));
  assign in_ready   = (state_q == FILL);
  assign out_valid  = (state_q == DRAIN);
  assign out_last   = out_valid && cnt_at_end;
  assign out_mean   = mean_q;
  assign wr_en      = in_ready && in_valid;

  // The RAM output register doubles as the hold register: a new read is only
  // issued when the current sample is taken, so stalls keep out_data stable.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_q == CALC) begin
      rd_en = 1'b1;
    end else if (state_q == DRAIN && out_ready && !cnt_at_end) begin
      rd_en   = 1'b1;
      rd_addr = AW'(cnt_q + 1'b1);
    end
  end

  assign diff     = $signed({1'b0, rd_data}) - $signed({1'b0, mean_q});
  assign out_data = out_valid ? diff : '0;

  win_buf #(
    .DATA_W(PIX_W),
    .DEPTH (N),
    .AW    (AW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(AW'(cnt_q)),
    .wr_data(in_data),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sum_q   <= '0;
      mean_q  <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            sum_q <= sum_q + SUM_W'(in_data);
            cnt_q <= cnt_q + 1'b1;
            if (cnt_at_end) state_q <= CALC;
          end
        end
        CALC: begin
          mean_q  <= PIX_W'(mean_of(64'(sum_q), LOG_N, ROUND_MEAN != 0));
          sum_q   <= '0;
          cnt_q   <= '0;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_ready) begin
            if (cnt_at_end) begin
              cnt_q   <= '0;
              state_q <= FILL;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_window_mean_stream.sv
// Randomised bench: two default-size instances (truncate / round) in lockstep plus a 4x4 12-bit one.
module tb_window_mean_stream;

  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       ir0, ov0, ol0, ir1, ov1, ol1;
  logic [8:0] od0, od1;
  logic [7:0] om0, om1;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
  logic [11:0] s_in_data, s_out_mean;
  logic [12:0] s_out_data;

  int checks = 0;
  int errors = 0;
  int pix[N];

  window_mean_stream #(.PIX_W(8), .WIN_DIM(16), .ROUND_MEAN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0), .out_mean(om0)
  );

  window_mean_stream #(.PIX_W(8), .WIN_DIM(16), .ROUND_MEAN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1), .out_mean(om1)
  );

  window_mean_stream #(.PIX_W(12), .WIN_DIM(4), .ROUND_MEAN(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .out_mean(s_out_mean)
  );

  function automatic int model_mean(bit rnd);
    int sum;
    sum = 0;
    foreach (pix[i]) sum += pix[i];
    return rnd ? (sum + N / 2) / N : sum / N;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || ol0 !== 1'b0 || od0 !== 9'd0 || om0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_out got valid=%b/%b last=%b data=%0d mean=%0d want 0", ov0, ov1, ol0,
               od0, om0);
    end
    checks++;
    if (ir0 !== 1'b1 || ir1 !== 1'b1 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b/%b/%b want 1", ir0, ir1, s_in_ready);
    end
  endtask

  // Feeds pix[] and ends on the negedge where out_valid should first be high.
  task automatic feed(int gap_pct);
    int i;
    i = 0;
    while (i < N) begin
      @(negedge clk);
      checks++;
      if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
        errors++;
        $display("FAIL fill_in_ready got %b/%b want 1", ir0, ir1);
      end
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = 8'(pix[i]);
        i++;
      end
    end
    @(negedge clk);
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b0 || ir1 !== 1'b0) begin
      errors++;
      $display("FAIL calc_cycle got valid=%b/%b ready=%b/%b want 0", ov0, ov1, ir0, ir1);
    end
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b1 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL latency got valid=%b/%b want 1 two cycles after last accept", ov0, ov1);
    end
  endtask

  task automatic drain(int stall_pct, int abort_at);
    int k, guard, m0, m1;
    logic [8:0] e0, e1;
    k = 0;
    guard = 0;
    m0 = model_mean(1'b0);
    m1 = model_mean(1'b1);
    while (k < N && guard < 20000) begin
      guard++;
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1 || ir1 !== 1'b1 || om0 !== 8'd0) begin
          errors++;
          $display("FAIL abort_reset got valid=%b/%b ready=%b/%b mean=%0d want 0/0 1/1 0", ov0,
                   ov1, ir0, ir1, om0);
        end
        return;
      end
      e0 = 9'(pix[k] - m0);
      e1 = 9'(pix[k] - m1);
      checks++;
      if (ov0 !== 1'b1 || ov1 !== 1'b1) begin
        errors++;
        $display("FAIL drain_valid sample %0d got %b/%b want 1", k, ov0, ov1);
      end
      checks++;
      if (od0 !== e0 || od1 !== e1) begin
        errors++;
        $display("FAIL drain_data sample %0d got %0d/%0d want %0d/%0d", k, $signed(od0),
                 $signed(od1), $signed(e0), $signed(e1));
      end
      checks++;
      if (ol0 !== (k == N - 1) || ol1 !== (k == N - 1)) begin
        errors++;
        $display("FAIL drain_last sample %0d got %b/%b want %b", k, ol0, ol1, k == N - 1);
      end
      checks++;
      if (om0 !== 8'(m0) || om1 !== 8'(m1) || ir0 !== 1'b0 || ir1 !== 1'b0) begin
        errors++;
        $display("FAIL drain_mean sample %0d got mean %0d/%0d ready %b/%b want %0d/%0d 0", k,
                 om0, om1, ir0, ir1, m0, m1);
      end
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_ready) k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (guard >= 20000) begin
      errors++;
      $display("FAIL drain_timeout got %0d samples want %0d", k, N);
    end
    checks++;
    if (ov0 !== 1'b0 || ov1 !== 1'b0 || ir0 !== 1'b1 || ir1 !== 1'b1) begin
      errors++;
      $display("FAIL drain_end got valid=%b/%b ready=%b/%b want 0/0 1/1", ov0, ov1, ir0, ir1);
    end
  endtask

  task automatic test_constant();
    foreach (pix[i]) pix[i] = 100;
    feed(0);
    drain(0, 0);
  endtask

  task automatic test_ramp();
    foreach (pix[i]) pix[i] = i;
    feed(0);
    drain(0, 0);
  endtask

  task automatic test_single_peak();
    foreach (pix[i]) pix[i] = 0;
    pix[$urandom_range(N - 1)] = 255;
    feed(0);
    drain(0, 0);
  endtask

  task automatic test_back_to_back_stalls();
    foreach (pix[i]) pix[i] = i;
    feed(30);
    drain(50, 0);
    foreach (pix[i]) pix[i] = int'($urandom_range(255));
    feed(20);
    drain(40, 0);
  endtask

  task automatic test_abort();
    foreach (pix[i]) pix[i] = int'($urandom_range(255));
    feed(10);
    drain(20, 100);
    foreach (pix[i]) pix[i] = 50;
    feed(0);
    drain(30, 0);
  endtask

  task automatic test_small_window();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_data  = 12'hfff;
      checks++;
      if (s_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL small_in_ready got %b want 1", s_in_ready);
      end
    end
    @(negedge clk);
    s_in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== 13'd0 || s_out_last !== (k == 15) ||
          s_out_mean !== 12'd4095) begin
        errors++;
        $display("FAIL small_drain sample %0d got v=%b d=%0d l=%b m=%0d want 1 0 %b 4095", k,
                 s_out_valid, s_out_data, s_out_last, s_out_mean, k == 15);
      end
    end
    @(negedge clk);
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL small_end got valid=%b ready=%b want 0 1", s_out_valid, s_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_single_peak();
    test_back_to_back_stalls();
    test_abort();
    test_small_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
